// File: rtl/sort_checker_pkg.sv
// Shared definitions for sort_checker: default geometry, error codes, FSM encoding.
package sort_checker_pkg;

  localparam int unsigned DEF_P_LOG = 1;
  localparam int unsigned DEF_DATW  = 64;
  localparam int unsigned DEF_KEYW  = 32;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ORDER   = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Lane-index width; a single-lane build still carries a 1-bit index.
  function automatic int unsigned lane_w(input int unsigned p_log);
    return (p_log > 0) ? p_log : 1;
  endfunction

endpackage

// File: rtl/key_order_cmp.sv
// Combinational lane-pair order check: ok_c when keys are non-decreasing from lane 0
// upward, err_lane_c is the lowest lane i with key[i] < key[i-1].
module key_order_cmp
  import sort_checker_pkg::*;
#(
  parameter int unsigned P_LOG = DEF_P_LOG,
  parameter int unsigned DATW  = DEF_DATW,
  parameter int unsigned KEYW  = DEF_KEYW
) (
  input  logic [(DATW<<P_LOG)-1:0] din,
  output logic                     ok_c,
  output logic [lane_w(P_LOG)-1:0] err_lane_c
);

  localparam int unsigned LANES = 1 << P_LOG;
  localparam int unsigned LW    = lane_w(P_LOG);

  // Payload bits above the key never take part in the compare.
  logic unused_din_c;
  assign unused_din_c = ^din;

  // Scan downward so the lowest violating lane is the one left standing.
  always_comb begin
    ok_c       = 1'b1;
    err_lane_c = '0;
    for (int i = int'(LANES) - 1; i >= 1; i--) begin
      if (din[DATW*i +: KEYW] < din[DATW*(i-1) +: KEYW]) begin
        ok_c       = 1'b0;
        err_lane_c = LW'(i);
      end
    end
  end

endmodule

// File: rtl/sort_checker.sv
// Sort-order checker for the mergesort network output: 3-stage pipeline, PASS/FAIL FSM,
// first-violation latch. Optional idle timeout enabled by SORT_CHECKER_TIMEOUT_EN.
module sort_checker
  import sort_checker_pkg::*;
#(
  parameter int unsigned P_LOG        = DEF_P_LOG,
  parameter int unsigned DATW         = DEF_DATW,
  parameter int unsigned KEYW         = DEF_KEYW,
  parameter int unsigned EXPECT_BEATS = 4,
  parameter int unsigned CNTW         = 16,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                     CLK,
  input  logic                     RST_X,
  input  logic                     START,
  input  logic [(DATW<<P_LOG)-1:0] DIN,
  input  logic                     DINEN,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     FAIL,
  output logic [1:0]               ERR_CODE,
  output logic [CNTW-1:0]          ERR_BEAT,
  output logic [lane_w(P_LOG)-1:0] ERR_LANE,
  output logic [CNTW-1:0]          BEAT_CNT
);

  localparam int unsigned     LW       = lane_w(P_LOG);
  localparam int unsigned     BUSW     = DATW << P_LOG;
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(EXPECT_BEATS - 1);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  state_t          state_q, state_d;
  err_code_t       err_code_q, err_code_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNTW-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNTW-1:0] err_beat_q, err_beat_d;
  logic [LW-1:0]   err_lane_q, err_lane_d;
  logic            accept;

  logic            s1_vld_q;
  logic [BUSW-1:0] s1_din_q;
  logic [CNTW-1:0] s1_idx_q;
  logic            s2_vld_q;
  logic            s2_ok_q;
  logic [LW-1:0]   s2_lane_q;
  logic [CNTW-1:0] s2_idx_q;
  logic            cmp_ok_c;
  logic [LW-1:0]   cmp_lane_c;

`ifdef SORT_CHECKER_TIMEOUT_EN
  localparam int unsigned IDLEW = $clog2(TIMEOUT + 1);
  logic [IDLEW-1:0] idle_q, idle_d;
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT;
`endif

  key_order_cmp #(
    .P_LOG (P_LOG),
    .DATW  (DATW),
    .KEYW  (KEYW)
  ) u_cmp (
    .din        (s1_din_q),
    .ok_c       (cmp_ok_c),
    .err_lane_c (cmp_lane_c)
  );

  // S1/S2: beat capture, then compare flags with the beat index they belong to.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      s1_vld_q  <= 1'b0;
      s1_din_q  <= '0;
      s1_idx_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_ok_q   <= 1'b0;
      s2_lane_q <= '0;
      s2_idx_q  <= '0;
    end else begin
      s1_vld_q  <= accept;
      s1_din_q  <= DIN;
      s1_idx_q  <= acc_cnt_q;
      s2_vld_q  <= s1_vld_q;
      s2_ok_q   <= cmp_ok_c;
      s2_lane_q <= cmp_lane_c;
      s2_idx_q  <= s1_idx_q;
    end
  end

  // S3 next-state: beats are judged only while RUN; DONE/FAIL hold until reset.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    err_code_d = err_code_q;
    err_beat_d = err_beat_q;
    err_lane_d = err_lane_q;
    accept     = 1'b0;
`ifdef SORT_CHECKER_TIMEOUT_EN
    idle_d     = idle_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_RUN;
          beat_cnt_d = '0;
          acc_cnt_d  = '0;
          err_code_d = ERR_NONE;
          err_beat_d = '0;
          err_lane_d = '0;
`ifdef SORT_CHECKER_TIMEOUT_EN
          idle_d     = '0;
`endif
        end
      end
      ST_RUN: begin
        accept = DINEN;
        if (accept) acc_cnt_d = sat_inc(acc_cnt_q);
        if (s2_vld_q) begin
          beat_cnt_d = sat_inc(beat_cnt_q);
          if (!s2_ok_q) begin
            state_d    = ST_FAIL;
            err_code_d = ERR_ORDER;
            err_beat_d = s2_idx_q;
            err_lane_d = s2_lane_q;
          end else if (beat_cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
`ifdef SORT_CHECKER_TIMEOUT_EN
        if (accept) idle_d = '0;
        else if (idle_q != IDLEW'(TIMEOUT)) idle_d = idle_q + IDLEW'(1);
        // A same-cycle violation already left RUN, so it wins over the timeout.
        if (state_d == ST_RUN && idle_q == IDLEW'(TIMEOUT)) begin
          state_d    = ST_FAIL;
          err_code_d = ERR_TIMEOUT;
          err_beat_d = beat_cnt_d;
          err_lane_d = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      acc_cnt_q  <= '0;
      err_code_q <= ERR_NONE;
      err_beat_q <= '0;
      err_lane_q <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      FAIL       <= 1'b0;
`ifdef SORT_CHECKER_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      err_code_q <= err_code_d;
      err_beat_q <= err_beat_d;
      err_lane_q <= err_lane_d;
      BUSY       <= (state_d == ST_RUN);
      DONE       <= (state_d == ST_DONE);
      FAIL       <= (state_d == ST_FAIL);
`ifdef SORT_CHECKER_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign ERR_CODE = err_code_q;
  assign ERR_BEAT = err_beat_q;
  assign ERR_LANE = err_lane_q;
  assign BEAT_CNT = beat_cnt_q;

endmodule

// File: tb/tb_sort_checker.sv
// Directed bench for sort_checker with a queue-based reference model checked every cycle.
module tb_sort_checker;

  localparam int unsigned P_LOG        = 1;
  localparam int unsigned DATW         = 64;
  localparam int unsigned KEYW         = 32;
  localparam int unsigned EXPECT_BEATS = 4;
  localparam int unsigned CNTW         = 16;
  localparam int unsigned TIMEOUT      = 16;
  localparam int          LANES        = 2;

  logic          CLK = 1'b0;
  logic          RST_X;
  logic          START;
  logic          DINEN;
  logic [127:0]  DIN;
  logic          BUSY, DONE, FAIL;
  logic [1:0]    ERR_CODE;
  logic [15:0]   ERR_BEAT;
  logic [0:0]    ERR_LANE;
  logic [15:0]   BEAT_CNT;

  sort_checker #(
    .P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW), .EXPECT_BEATS(EXPECT_BEATS),
    .CNTW(CNTW), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_X(RST_X), .START(START), .DIN(DIN), .DINEN(DINEN),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .ERR_CODE(ERR_CODE),
    .ERR_BEAT(ERR_BEAT), .ERR_LANE(ERR_LANE), .BEAT_CNT(BEAT_CNT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done, 3 fail. A beat accepted at an edge
  // is judged two edges later, so its result is visible in the third cycle.
  typedef struct {
    logic [31:0] k[LANES];
    int          due;
    int          idx;
  } beat_t;

  beat_t pend[$];
  int    m_state = 0;
  int    m_cnt = 0, m_acc = 0, m_code = 0, m_beat = 0, m_lane = 0, m_last = 0;
  int    edge_n = 0;
  bit    model_live = 1'b0;

  always @(posedge CLK) begin
    int    was;
    int    viol;
    beat_t b;
    edge_n++;
    model_live = 1'b1;
    if (!RST_X) begin
      m_state = 0; m_cnt = 0; m_acc = 0; m_code = 0; m_beat = 0; m_lane = 0;
      pend.delete();
    end else begin
      was = m_state;
      if (pend.size() != 0 && pend[0].due == edge_n) begin
        b = pend.pop_front();
        if (was == 1) begin
          viol = 0;
          for (int i = 1; i < LANES; i++)
            if (viol == 0 && b.k[i] < b.k[i-1]) viol = i;
          if (m_cnt < 65535) m_cnt++;
          if (viol != 0) begin
            m_state = 3; m_code = 1; m_beat = b.idx; m_lane = viol;
          end else if (m_cnt == int'(EXPECT_BEATS)) begin
            m_state = 2;
          end
        end
      end
`ifdef SORT_CHECKER_TIMEOUT_EN
      if (was == 1 && m_state == 1 && edge_n - m_last > int'(TIMEOUT)) begin
        m_state = 3; m_code = 2; m_beat = m_cnt; m_lane = 0;
      end
      if (was == 1 && DINEN) m_last = edge_n;
`endif
      if (was == 1 && DINEN) begin
        b.k[0] = DIN[31:0];
        b.k[1] = DIN[95:64];
        b.due  = edge_n + 2;
        b.idx  = m_acc;
        if (m_acc < 65535) m_acc++;
        pend.push_back(b);
      end
      if (was == 0 && START) begin
        m_state = 1; m_cnt = 0; m_acc = 0; m_code = 0; m_beat = 0; m_lane = 0;
        m_last = edge_n;
      end
    end
  end

  // Every cycle: all outputs against the model, sampled mid-cycle.
  always @(negedge CLK) begin
    if (model_live) begin
      chk("busy",     32'(BUSY),     32'(m_state == 1));
      chk("done",     32'(DONE),     32'(m_state == 2));
      chk("fail",     32'(FAIL),     32'(m_state == 3));
      chk("err_code", 32'(ERR_CODE), 32'(m_code));
      chk("err_beat", 32'(ERR_BEAT), 32'(m_beat));
      chk("err_lane", 32'(ERR_LANE), 32'(m_lane));
      chk("beat_cnt", 32'(BEAT_CNT), 32'(m_cnt));
    end
  end

  // One cycle of stimulus; upper record halves carry random non-key payload.
  task automatic cyc(input logic st, input logic en, input logic [31:0] k1, input logic [31:0] k0);
    START = st;
    DINEN = en;
    DIN   = {$urandom(), k1, $urandom(), k0};
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    RST_X = 1'b1;
  endtask

  initial begin
    RST_X = 1'b0; START = 1'b0; DINEN = 1'b0; DIN = '0;
    @(negedge CLK);
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_flags", 32'({DONE, FAIL, ERR_CODE}), 32'd0);
    chk("rst_cnt", 32'(BEAT_CNT), 32'd0);
    RST_X = 1'b1;

    // DINEN while idle is dropped.
    repeat (3) cyc(1'b0, 1'b1, 32'd7, 32'd1);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    chk("idle_cnt", 32'(BEAT_CNT), 32'd0);

    // Good run, then beats after completion (one of them out of order).
    cyc(1'b1, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 32'd2, 32'd1);
    cyc(1'b0, 1'b1, 32'd5, 32'd5);
    cyc(1'b0, 1'b1, 32'd9, 32'd3);
    cyc(1'b0, 1'b1, 32'd7, 32'd0);
    cyc(1'b0, 1'b1, 32'd1, 32'd9);
    chk("done_early", 32'(DONE), 32'd0);
    cyc(1'b0, 1'b1, 32'd0, 32'd0);
    chk("done_lat", 32'(DONE), 32'd1);
    chk("done_cnt", 32'(BEAT_CNT), 32'd4);
    repeat (4) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    chk("frozen_cnt", 32'(BEAT_CNT), 32'd4);
    chk("done_nofail", 32'({FAIL, ERR_CODE}), 32'd0);
    cyc(1'b1, 1'b1, 32'd3, 32'd3);
    chk("start_in_done", 32'({BUSY, DONE}), 32'b01);

    // Violation on beat 1, later good beats must not disturb the latch.
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 32'd2, 32'd1);
    cyc(1'b0, 1'b1, 32'd1, 32'd2);
    cyc(1'b0, 1'b1, 32'd3, 32'd3);
    cyc(1'b0, 1'b1, 32'd5, 32'd4);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    chk("v_fail", 32'({DONE, FAIL}), 32'b01);
    chk("v_code", 32'(ERR_CODE), 32'd1);
    chk("v_beat", 32'(ERR_BEAT), 32'd1);
    chk("v_lane", 32'(ERR_LANE), 32'd1);

    // Last expected beat violates: FAIL, not DONE.
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 32'd1, 32'd0);
    cyc(1'b0, 1'b1, 32'd2, 32'd2);
    cyc(1'b0, 1'b1, 32'd4, 32'd3);
    cyc(1'b0, 1'b1, 32'd0, 32'd8);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    chk("last_fail", 32'({DONE, FAIL}), 32'b01);
    chk("last_beat", 32'(ERR_BEAT), 32'd3);
    chk("last_code", 32'(ERR_CODE), 32'd1);

    // Stall after one beat.
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 32'd6, 32'd4);
    repeat (20) cyc(1'b0, 1'b0, 32'd0, 32'd0);
`ifdef SORT_CHECKER_TIMEOUT_EN
    chk("to_fail", 32'({BUSY, FAIL}), 32'b01);
    chk("to_code", 32'(ERR_CODE), 32'd2);
    chk("to_beat", 32'(ERR_BEAT), 32'd1);
    chk("to_lane", 32'(ERR_LANE), 32'd0);
`else
    chk("stall_busy", 32'({BUSY, FAIL}), 32'b10);
    chk("stall_cnt", 32'(BEAT_CNT), 32'd1);
`endif

    // Reset with beats in flight, then a fresh run (DINEN with START is dropped).
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 32'd1, 32'd0);
    cyc(1'b0, 1'b1, 32'd0, 32'd9);
    RST_X = 1'b0;
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
    chk("mid_rst", 32'({BUSY, DONE, FAIL, ERR_CODE}), 32'd0);
    chk("mid_rst_cnt", 32'(BEAT_CNT), 32'd0);
    RST_X = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    chk("flush_fail", 32'(FAIL), 32'd0);
    cyc(1'b1, 1'b1, 32'd0, 32'd5);
    cyc(1'b0, 1'b1, 32'd1, 32'd1);
    cyc(1'b0, 1'b1, 32'd3, 32'd2);
    cyc(1'b0, 1'b1, 32'd8, 32'd4);
    cyc(1'b0, 1'b1, 32'd8, 32'd8);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    chk("rerun_done", 32'({DONE, FAIL}), 32'b10);
    chk("rerun_cnt", 32'(BEAT_CNT), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
